// File: rtl/av2_mv_symbol_decoder.sv
// Rebuilds one or two motion vectors from entropy-decoded joint/sign/magnitude symbols.
// Optional build macro AV2_MV_CLAMP_EN: saturate reconstructed components instead of wrapping.
module av2_mv_symbol_decoder #(
   parameter int MV_W       = 16,
   parameter int SYM_W      = 16,
   parameter int MAG_W      = 10,
   parameter int PREC_SHIFT = 3,
   parameter int CTX_BASE   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              compound,
   input  logic [MV_W-1:0]   pred0_x,
   input  logic [MV_W-1:0]   pred0_y,
   input  logic [MV_W-1:0]   pred1_x,
   input  logic [MV_W-1:0]   pred1_y,
   output logic [15:0]       context_idx,
   input  logic [SYM_W-1:0]  decoded_symbol,
   input  logic              symbol_valid,
   output logic              symbol_ready,
   output logic [MV_W-1:0]   mv_x,
   output logic [MV_W-1:0]   mv_y,
   output logic              mv_idx,
   output logic              mv_valid,
   input  logic              mv_ready,
   output logic              sym_err,
   output logic              done,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE, S_JOINT, S_SIGN_X, S_MAG_X, S_SIGN_Y, S_MAG_Y, S_SUM, S_OUT
   } state_t;

   localparam logic [MV_W:0] ONE_W = 1;

   state_t            state, state_nx;
   logic              cmp_q;
   logic [MV_W-1:0]   p0x_q, p0y_q, p1x_q, p1y_q;
   logic [1:0]        joint_q;
   logic              neg_x_q, neg_y_q;
   logic [MAG_W-1:0]  mag_x_q, mag_y_q;
   logic [15:0]       ctx_off;
   logic              sym_hi;
   logic              sym_xfer, mv_xfer;
   logic [MV_W-1:0]   pred_x, pred_y;

   // Handshakes: a symbol moves when symbol_valid & symbol_ready and an MV moves when
   // mv_valid & mv_ready, both on the rising clock edge; neither ready nor valid depends on its partner.
   assign sym_xfer  = symbol_valid & symbol_ready;
   assign mv_xfer   = mv_valid & mv_ready;
   assign state_dbg = state;
   assign pred_x    = mv_idx ? p1x_q : p0x_q;
   assign pred_y    = mv_idx ? p1y_q : p0y_q;

   // Difference is always positive and narrower than MV_W, so MV_W+1 bits hold the exact sum.
   function automatic logic [MV_W-1:0] recon(input logic [MV_W-1:0] pred, input logic neg,
                                             input logic [MAG_W-1:0] mag);
      logic [MV_W:0] diff, sum;
      diff = ({{(MV_W+1-MAG_W){1'b0}}, mag} + ONE_W) << PREC_SHIFT;
      sum  = neg ? ({pred[MV_W-1], pred} - diff) : ({pred[MV_W-1], pred} + diff);
`ifdef AV2_MV_CLAMP_EN
      if (sum[MV_W] != sum[MV_W-1])
         recon = sum[MV_W] ? {1'b1, {(MV_W-1){1'b0}}} : {1'b0, {(MV_W-1){1'b1}}};
      else
         recon = sum[MV_W-1:0];
`else
      recon = sum[MV_W-1:0];
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      symbol_ready = 1'b0;
      mv_valid     = 1'b0;
      done         = 1'b0;
      ctx_off      = 16'd0;
      case (state)
         S_IDLE: begin
            done = 1'b1;
            if (start) state_nx = S_JOINT;
         end
         S_JOINT: begin
            symbol_ready = 1'b1;
            if (sym_xfer) begin
               if (decoded_symbol[0])      state_nx = S_SIGN_X;
               else if (decoded_symbol[1]) state_nx = S_SIGN_Y;
               else                        state_nx = S_SUM;
            end
         end
         S_SIGN_X: begin
            symbol_ready = 1'b1;
            ctx_off      = 16'd1;
            if (sym_xfer) state_nx = S_MAG_X;
         end
         S_MAG_X: begin
            symbol_ready = 1'b1;
            ctx_off      = 16'd2;
            if (sym_xfer) state_nx = joint_q[1] ? S_SIGN_Y : S_SUM;
         end
         S_SIGN_Y: begin
            symbol_ready = 1'b1;
            ctx_off      = 16'd3;
            if (sym_xfer) state_nx = S_MAG_Y;
         end
         S_MAG_Y: begin
            symbol_ready = 1'b1;
            ctx_off      = 16'd4;
            if (sym_xfer) state_nx = S_SUM;
         end
         S_SUM: state_nx = S_OUT;
         S_OUT: begin
            mv_valid = 1'b1;
            if (mv_xfer) state_nx = (cmp_q && !mv_idx) ? S_JOINT : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign context_idx = symbol_ready ? (16'(CTX_BASE) + ctx_off + (mv_idx ? 16'd5 : 16'd0)) : 16'd0;

   always_comb begin
      sym_hi = 1'b0;
      case (state)
         S_JOINT:            sym_hi = |decoded_symbol[SYM_W-1:2];
         S_SIGN_X, S_SIGN_Y: sym_hi = |decoded_symbol[SYM_W-1:1];
         S_MAG_X, S_MAG_Y:   sym_hi = |decoded_symbol[SYM_W-1:MAG_W];
         default:            sym_hi = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_q   <= 1'b0;
         p0x_q   <= '0;
         p0y_q   <= '0;
         p1x_q   <= '0;
         p1y_q   <= '0;
         joint_q <= 2'b00;
         neg_x_q <= 1'b0;
         neg_y_q <= 1'b0;
         mag_x_q <= '0;
         mag_y_q <= '0;
         mv_idx  <= 1'b0;
         mv_x    <= '0;
         mv_y    <= '0;
         sym_err <= 1'b0;
      end else begin
         if (sym_xfer && sym_hi) sym_err <= 1'b1;
         case (state)
            S_IDLE: if (start) begin
               cmp_q   <= compound;
               p0x_q   <= pred0_x;
               p0y_q   <= pred0_y;
               p1x_q   <= pred1_x;
               p1y_q   <= pred1_y;
               mv_idx  <= 1'b0;
               sym_err <= 1'b0;
            end
            S_JOINT:  if (sym_xfer) joint_q <= decoded_symbol[1:0];
            S_SIGN_X: if (sym_xfer) neg_x_q <= decoded_symbol[0];
            S_MAG_X:  if (sym_xfer) mag_x_q <= decoded_symbol[MAG_W-1:0];
            S_SIGN_Y: if (sym_xfer) neg_y_q <= decoded_symbol[0];
            S_MAG_Y:  if (sym_xfer) mag_y_q <= decoded_symbol[MAG_W-1:0];
            S_SUM: begin
               mv_x <= joint_q[0] ? recon(pred_x, neg_x_q, mag_x_q) : pred_x;
               mv_y <= joint_q[1] ? recon(pred_y, neg_y_q, mag_y_q) : pred_y;
            end
            S_OUT: if (mv_xfer) mv_idx <= cmp_q && !mv_idx;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_av2_mv_symbol_decoder.sv
// Scoreboard bench for av2_mv_symbol_decoder; expected MVs come from an integer model of the decode rules.
// Honours AV2_MV_CLAMP_EN the same way the design does (saturate vs. wrap).
module tb_av2_mv_symbol_decoder;
   localparam int MV_W = 16, SYM_W = 16, MAG_W = 10, PREC_SHIFT = 3, CTX_BASE = 0;

   logic             clk = 0, rst = 1, start = 0, compound = 0;
   logic [MV_W-1:0]  pred0_x = '0, pred0_y = '0, pred1_x = '0, pred1_y = '0;
   logic [15:0]      context_idx;
   logic [SYM_W-1:0] decoded_symbol = '0;
   logic             symbol_valid = 0, symbol_ready;
   logic [MV_W-1:0]  mv_x, mv_y;
   logic             mv_idx, mv_valid, mv_ready = 0, sym_err, done;
   logic [2:0]       state_dbg;

   av2_mv_symbol_decoder #(.MV_W(MV_W), .SYM_W(SYM_W), .MAG_W(MAG_W),
                           .PREC_SHIFT(PREC_SHIFT), .CTX_BASE(CTX_BASE)) dut (
      .clk(clk), .rst(rst), .start(start), .compound(compound),
      .pred0_x(pred0_x), .pred0_y(pred0_y), .pred1_x(pred1_x), .pred1_y(pred1_y),
      .context_idx(context_idx), .decoded_symbol(decoded_symbol),
      .symbol_valid(symbol_valid), .symbol_ready(symbol_ready),
      .mv_x(mv_x), .mv_y(mv_y), .mv_idx(mv_idx), .mv_valid(mv_valid), .mv_ready(mv_ready),
      .sym_err(sym_err), .done(done), .state_dbg(state_dbg));

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0;
   bit exp_err = 0, hold_low = 0;
   logic [2*MV_W:0]  exp_q[$];
   logic [SYM_W-1:0] sym_q[$];
   logic [15:0]      ctx_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   // Reference arithmetic on plain integers.
   function automatic int reduce(input int v);
      int span, r;
      span = 1 << MV_W;
`ifdef AV2_MV_CLAMP_EN
      r = v;
      if (v > span / 2 - 1) r = span / 2 - 1;
      if (v < -span / 2)    r = -span / 2;
`else
      r = v % span;
      if (r < 0) r += span;
      if (r >= span / 2) r -= span;
`endif
      return r;
   endfunction

   function automatic int component(input int pred, input int sign_sym, input int mag_sym);
      int diff;
      diff = ((mag_sym % (1 << MAG_W)) + 1) * (1 << PREC_SHIFT);
      return reduce((sign_sym % 2 == 1) ? pred - diff : pred + diff);
   endfunction

   function automatic int rand_sym(input int limit);
      int v;
      v = $urandom_range(0, limit - 1);
      if ($urandom_range(0, 7) == 0) v += limit * $urandom_range(1, 65536 / limit - 1);
      return v;
   endfunction

   function automatic int rand_pred();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic push_sym(input int s, input int ctx, input int limit);
      int c;
      c = CTX_BASE + ctx;
      if (s >= limit) exp_err = 1;
      sym_q.push_back(s[SYM_W-1:0]);
      ctx_q.push_back(c[15:0]);
   endtask

   task automatic add_mv(input int idx, input int px, input int py, input int jsym,
                         input int sxs, input int mxs, input int sys, input int mys);
      int j, x, y;
      logic [MV_W-1:0] xv, yv;
      j = jsym % 4;
      x = px;
      y = py;
      push_sym(jsym, 5 * idx, 4);
      if (j % 2 == 1) begin
         push_sym(sxs, 1 + 5 * idx, 2);
         push_sym(mxs, 2 + 5 * idx, 1 << MAG_W);
         x = component(px, sxs, mxs);
      end
      if (j >= 2) begin
         push_sym(sys, 3 + 5 * idx, 2);
         push_sym(mys, 4 + 5 * idx, 1 << MAG_W);
         y = component(py, sys, mys);
      end
      xv = x[MV_W-1:0];
      yv = y[MV_W-1:0];
      exp_q.push_back({idx[0], xv, yv});
   endtask

   task automatic pulse_start(input bit cmp, input int p0x, input int p0y, input int p1x, input int p1y);
      start = 1; compound = cmp;
      pred0_x = p0x[MV_W-1:0]; pred0_y = p0y[MV_W-1:0];
      pred1_x = p1x[MV_W-1:0]; pred1_y = p1y[MV_W-1:0];
      @(negedge clk);
      // Scramble inputs: the decoder must use only the values latched with start.
      start = 0; compound = 1'($urandom);
      pred0_x = MV_W'($urandom); pred0_y = MV_W'($urandom);
      pred1_x = MV_W'($urandom); pred1_y = MV_W'($urandom);
   endtask

   task automatic run_decode(input bit cmp, input int p0x, input int p0y, input int p1x, input int p1y);
      int t;
      t = 0;
      while (!done && t < 200) begin @(negedge clk); t++; end
      pulse_start(cmp, p0x, p0y, p1x, p1y);
      t = 0;
      while (!(done && exp_q.size() == 0 && sym_q.size() == 0) && t < 3000) begin
         @(negedge clk); t++;
      end
      check("decode_completes", t < 3000, 1);
      if (t >= 3000) begin exp_q.delete(); sym_q.delete(); ctx_q.delete(); end
      check("sym_err", sym_err, exp_err);
      exp_err = 0;
   endtask

   // Symbol driver and MV monitor, both acting on the falling edge.
   initial begin
      logic [2*MV_W:0] last, got, exp;
      bit have_last;
      have_last = 0;
      last = '0;
      forever begin
         @(negedge clk);
         if (symbol_ready && sym_q.size() > 0 && $urandom_range(0, 9) < 7) begin
            check("context_idx", context_idx, ctx_q.pop_front());
            decoded_symbol = sym_q.pop_front();
            symbol_valid   = 1;
         end else if (!symbol_ready && $urandom_range(0, 3) == 0) begin
            decoded_symbol = SYM_W'($urandom);
            symbol_valid   = 1;
         end else begin
            symbol_valid = 0;
         end
         if (mv_valid) begin
            got = {mv_idx, mv_x, mv_y};
            check("ready_excl_valid", symbol_ready, 0);
            if (have_last) check("mv_stable", got, last);
            if (!hold_low && $urandom_range(0, 3) != 0) begin
               mv_ready  = 1;
               have_last = 0;
               if (exp_q.size() == 0) check("mv_unexpected", got, '1);
               else begin
                  exp = exp_q.pop_front();
                  check("mv_out", got, exp);
               end
            end else begin
               mv_ready  = 0;
               last      = got;
               have_last = 1;
            end
         end else begin
            mv_ready  = 1'($urandom);
            have_last = 0;
         end
      end
   end

   initial begin
      int t, p0x, p0y, p1x, p1y;
      bit cmp;
      repeat (3) @(negedge clk);
      rst = 0;
      check("rst_done", done, 1);
      check("rst_mv_valid", mv_valid, 0);
      check("rst_symbol_ready", symbol_ready, 0);
      check("rst_sym_err", sym_err, 0);
      check("rst_mv", {mv_idx, mv_x, mv_y}, 0);
      check("rst_ctx", context_idx, 0);

      add_mv(0, 5, -3, 0, 0, 0, 0, 0);
      run_decode(0, 5, -3, 0, 0);
      add_mv(0, 0, 0, 3, 1, 1, 0, 0);
      run_decode(0, 0, 0, 0, 0);
      add_mv(0, 0, 0, 1, 0, 0, 0, 0);
      add_mv(1, 0, 0, 2, 0, 0, 1, 2);
      run_decode(1, 0, 0, 0, 0);
      add_mv(0, 32760, 0, 1, 0, 1, 0, 0);
      run_decode(0, 32760, 0, 0, 0);
      add_mv(0, 5, -3, 4, 0, 0, 0, 0);
      run_decode(0, 5, -3, 0, 0);
      add_mv(0, -32768, 32767, 3, 1, 1023, 0, 1023);
      run_decode(0, -32768, 32767, 0, 0);

      // Downstream stall: MV must hold, no symbols requested, start ignored.
      hold_low = 1;
      add_mv(0, 100, -200, 3, 0, 5, 1, 7);
      pulse_start(0, 100, -200, 0, 0);
      t = 0;
      while (!mv_valid && t < 500) begin @(negedge clk); t++; end
      check("hold_reach_out", t < 500, 1);
      for (int i = 0; i < 10; i++) begin
         start = i[0];
         @(negedge clk);
         check("hold_valid", mv_valid, 1);
         check("hold_done", done, 0);
      end
      hold_low = 0;
      t = 0;
      while (mv_valid && t < 200) begin start = 1; @(negedge clk); t++; end
      start = 0;
      @(negedge clk);
      check("start_at_out_ignored", {done, symbol_ready, mv_valid}, 3'b100);
      check("hold_drained", exp_q.size(), 0);

      // Reset while waiting in MAG_X: decode abandoned, nothing emitted.
      push_sym(3, 0, 4);
      push_sym(1, 1, 2);
      pulse_start(0, 7, 7, 0, 0);
      t = 0;
      while (sym_q.size() > 0 && t < 200) begin @(negedge clk); t++; end
      repeat (2) @(negedge clk);
      check("wait_mag_x", {symbol_ready, context_idx}, {1'b1, 16'd2});
      rst = 1;
      @(negedge clk);
      check("abort_state", {done, mv_valid, symbol_ready, sym_err}, 4'b1000);
      rst = 0;
      exp_err = 0;
      add_mv(0, 1, 2, 2, 0, 3, 0, 0);
      run_decode(0, 1, 2, 0, 0);

      for (int n = 0; n < 40; n++) begin
         cmp = 1'($urandom);
         p0x = rand_pred(); p0y = rand_pred(); p1x = rand_pred(); p1y = rand_pred();
         add_mv(0, p0x, p0y, rand_sym(4), rand_sym(2), rand_sym(1 << MAG_W), rand_sym(2), rand_sym(1 << MAG_W));
         if (cmp)
            add_mv(1, p1x, p1y, rand_sym(4), rand_sym(2), rand_sym(1 << MAG_W), rand_sym(2), rand_sym(1 << MAG_W));
         run_decode(cmp, p0x, p0y, p1x, p1y);
      end

      repeat (3) @(negedge clk);
      check("queues_empty", {exp_q.size() == 0, sym_q.size() == 0}, 2'b11);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
